// File: rtl/execute_unit_mc.sv
// rtl/execute_unit_mc.sv - Execute stage with operand forwarding, iterative multiplier and Z/V/N flags
module execute_unit_mc #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4,
    parameter int MUL_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [3:0]          opcode,
    input  logic [WIDTH-1:0]    reg1,
    input  logic [WIDTH-1:0]    reg2,
    input  logic [WIDTH-1:0]    imm,
    input  logic                alu_src,
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    input  logic                reg_write,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                xm_reg_write,
    input  logic [REG_BITS-1:0] xm_rd,
    input  logic [WIDTH-1:0]    xm_alu,
    input  logic                mw_reg_write,
    input  logic [REG_BITS-1:0] mw_rd,
    input  logic [WIDTH-1:0]    mw_data,
    output logic                stall,
    output logic                out_valid,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic [WIDTH-1:0]    out_alu,
    output logic [WIDTH-1:0]    out_store_data,
    output logic [REG_BITS-1:0] out_rd,
    output logic [2:0]          flags
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_LHB = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1111;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ADDR_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]    fwd_a, fwd_b, b_op;
    logic [WIDTH:0]      sum_ext, dif_ext;
    logic [3:0]          shamt;
    logic [WIDTH-1:0]    alu_result;
    logic                ovf, upd_zvn, upd_z, alu_z;
    logic                is_mul, start_mul;

    logic [WIDTH-1:0]    mul_a, mul_b, mul_acc, mul_store;
    logic [CW-1:0]       count;
    logic [REG_BITS-1:0] mul_rd;
    logic                mul_reg_write, mul_mem_read, mul_mem_write;

    // EX/MEM result is newer than MEM/WB, so it wins when both target the same register
    always_comb begin
        fwd_a = reg1;
        if (xm_reg_write && xm_rd == rs && rs != '0)
            fwd_a = xm_alu;
        else if (mw_reg_write && mw_rd == rs && rs != '0)
            fwd_a = mw_data;

        fwd_b = reg2;
        if (xm_reg_write && xm_rd == rt && rt != '0)
            fwd_b = xm_alu;
        else if (mw_reg_write && mw_rd == rt && rt != '0)
            fwd_b = mw_data;
    end

    assign b_op    = alu_src ? imm : fwd_b;
    assign sum_ext = {fwd_a[WIDTH-1], fwd_a} + {b_op[WIDTH-1], b_op};
    assign dif_ext = {fwd_a[WIDTH-1], fwd_a} - {b_op[WIDTH-1], b_op};
    assign shamt   = b_op[3:0];

    always_comb begin
        alu_result = '0;
        ovf        = 1'b0;
        upd_zvn    = 1'b0;
        upd_z      = 1'b0;
        case (opcode)
            OP_ADD: begin
                ovf        = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
                alu_result = ovf ? (sum_ext[WIDTH] ? SAT_MIN : SAT_MAX) : sum_ext[WIDTH-1:0];
                upd_zvn    = 1'b1;
            end
            OP_SUB: begin
                ovf        = dif_ext[WIDTH] ^ dif_ext[WIDTH-1];
                alu_result = ovf ? (dif_ext[WIDTH] ? SAT_MIN : SAT_MAX) : dif_ext[WIDTH-1:0];
                upd_zvn    = 1'b1;
            end
            OP_XOR: begin
                alu_result = fwd_a ^ b_op;
                upd_z      = 1'b1;
            end
            OP_SLL: begin
                alu_result = fwd_a << shamt;
                upd_z      = 1'b1;
            end
            OP_SRA: begin
                alu_result = $signed(fwd_a) >>> shamt;
                upd_z      = 1'b1;
            end
            OP_ROR: begin
                // a zero rotate shifts the left term out entirely, leaving fwd_a
                alu_result = (fwd_a >> shamt) | (fwd_a << (WIDTH - int'(shamt)));
                upd_z      = 1'b1;
            end
            OP_LW, OP_SW: alu_result = (fwd_a + imm) & ADDR_MASK;
            OP_LLB:       alu_result = {fwd_a[WIDTH-1:8], imm[7:0]};
            OP_LHB: begin
                alu_result        = fwd_a;
                alu_result[15:8]  = imm[7:0];
            end
            default: alu_result = '0;
        endcase
    end

    assign alu_z     = (alu_result == '0);
    assign is_mul    = (MUL_EN != 0) && (opcode == OP_MUL);
    assign start_mul = in_valid && is_mul && !flush && (state == IDLE || state == DONE);
    assign stall     = (state == RUN) || (state == IDLE && in_valid && is_mul);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = RUN;
            RUN:     if (flush) state_next = IDLE;
                     else if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = start_mul ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Shift-add multiplier; control bits are captured with the operands so DONE needs no upstream hold
    always_ff @(posedge clk) begin
        if (start_mul) begin
            mul_a         <= fwd_a;
            mul_b         <= b_op;
            mul_acc       <= '0;
            count         <= CW'(WIDTH);
            mul_rd        <= rd;
            mul_reg_write <= reg_write;
            mul_mem_read  <= mem_read;
            mul_mem_write <= mem_write;
            mul_store     <= fwd_b;
        end else if (state == RUN) begin
            if (mul_b[0])
                mul_acc <= mul_acc + mul_a;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_alu        <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            flags          <= 3'b000;
        end else if (flush || (stall && state != DONE)) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_alu        <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
        end else if (state == DONE) begin
            out_valid      <= 1'b1;
            out_reg_write  <= mul_reg_write;
            out_mem_read   <= mul_mem_read;
            out_mem_write  <= mul_mem_write;
            out_alu        <= mul_acc;
            out_store_data <= mul_store;
            out_rd         <= mul_rd;
            flags[2]       <= (mul_acc == '0);
        end else begin
            out_valid      <= in_valid;
            out_reg_write  <= in_valid & reg_write;
            out_mem_read   <= in_valid & mem_read;
            out_mem_write  <= in_valid & mem_write;
            out_alu        <= alu_result;
            out_store_data <= fwd_b;
            out_rd         <= rd;
            if (in_valid && upd_zvn)
                flags <= {alu_z, ovf, alu_result[WIDTH-1]};
            else if (in_valid && upd_z)
                flags[2] <= alu_z;
        end
    end

endmodule

// File: tb/tb_execute_unit_mc.sv
// tb/tb_execute_unit_mc.sv - Directed self-checking bench for execute_unit_mc
module tb_execute_unit_mc;
    localparam int W  = 16;
    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, alu_src;
    logic [3:0]    opcode;
    logic [W-1:0]  reg1, reg2, imm, xm_alu, mw_data;
    logic [RB-1:0] rs, rt, rd, xm_rd, mw_rd;
    logic          reg_write, mem_read, mem_write, xm_reg_write, mw_reg_write;
    logic          stall, out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [W-1:0]  out_alu, out_store_data;
    logic [RB-1:0] out_rd;
    logic [2:0]    flags;

    int n_cmp = 0;
    int n_bad = 0;

    execute_unit_mc #(.WIDTH(W), .REG_BITS(RB), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .opcode(opcode),
        .reg1(reg1), .reg2(reg2), .imm(imm), .alu_src(alu_src),
        .rs(rs), .rt(rt), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .xm_reg_write(xm_reg_write), .xm_rd(xm_rd), .xm_alu(xm_alu),
        .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_data(mw_data),
        .stall(stall), .out_valid(out_valid), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_alu(out_alu), .out_store_data(out_store_data), .out_rd(out_rd), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; opcode = 4'h0; alu_src = 0;
        reg1 = '0; reg2 = '0; imm = '0; rs = '0; rt = '0; rd = '0;
        reg_write = 0; mem_read = 0; mem_write = 0;
        xm_reg_write = 0; xm_rd = '0; xm_alu = '0;
        mw_reg_write = 0; mw_rd = '0; mw_data = '0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic use_imm, input logic [W-1:0] immv, input logic [RB-1:0] dst);
        in_valid = 1; opcode = op; reg1 = a; reg2 = b; alu_src = use_imm; imm = immv;
        rs = 4'd1; rt = 4'd2; rd = dst; reg_write = 1; mem_read = 0; mem_write = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_alu !== 16'h0000) begin n_bad++; $display("FAIL reset_alu got %h want 0000", out_alu); end
        n_cmp++; if (out_rd !== 4'h0 || out_reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl got rd=%h rw=%b want 0/0", out_rd, out_reg_write); end
        n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", flags); end
        rst = 0;
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        drive_op(4'b0000, 16'h0100, 16'h0ABC, 1'b1, 16'h0001, 4'd7);
        rs = 4'd3; rt = 4'd5;
        xm_reg_write = 1; xm_rd = 4'd3; xm_alu = 16'h0010;
        mw_reg_write = 1; mw_rd = 4'd3; mw_data = 16'h0020;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fwd_stall got %b want 0", stall); end
        tick();
        n_cmp++; if (out_alu !== 16'h0011) begin n_bad++; $display("FAIL fwd_xm_prio got %h want 0011", out_alu); end
        n_cmp++; if (out_valid !== 1'b1 || out_rd !== 4'd7 || out_reg_write !== 1'b1) begin n_bad++; $display("FAIL fwd_ctrl got v=%b rd=%h rw=%b want 1/7/1", out_valid, out_rd, out_reg_write); end
        n_cmp++; if (out_store_data !== 16'h0ABC) begin n_bad++; $display("FAIL fwd_store_rf got %h want 0abc", out_store_data); end
        n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL fwd_flags got %b want 000", flags); end
        rs = 4'd0; xm_rd = 4'd0; mw_rd = 4'd0;
        tick();
        n_cmp++; if (out_alu !== 16'h0101) begin n_bad++; $display("FAIL fwd_r0 got %h want 0101", out_alu); end
        rs = 4'd3; rt = 4'd6; xm_rd = 4'd6; mw_rd = 4'd3;
        tick();
        n_cmp++; if (out_alu !== 16'h0021) begin n_bad++; $display("FAIL fwd_mw got %h want 0021", out_alu); end
        n_cmp++; if (out_store_data !== 16'h0010) begin n_bad++; $display("FAIL fwd_store_xm got %h want 0010", out_store_data); end
    endtask

    task automatic test_saturation();
        clear_inputs();
        drive_op(4'b0000, 16'h7FFF, 16'h0000, 1'b1, 16'h0001, 4'd1);
        tick();
        n_cmp++; if (out_alu !== 16'h7FFF || flags !== 3'b010) begin n_bad++; $display("FAIL sat_add got %h/%b want 7fff/010", out_alu, flags); end
        drive_op(4'b0001, 16'h8000, 16'h0000, 1'b1, 16'h0001, 4'd1);
        tick();
        n_cmp++; if (out_alu !== 16'h8000 || flags !== 3'b011) begin n_bad++; $display("FAIL sat_sub got %h/%b want 8000/011", out_alu, flags); end
        drive_op(4'b0000, 16'h0005, 16'hFFFB, 1'b0, 16'h0000, 4'd1);
        tick();
        n_cmp++; if (out_alu !== 16'h0000 || flags !== 3'b100) begin n_bad++; $display("FAIL add_zero got %h/%b want 0000/100", out_alu, flags); end
    endtask

    task automatic test_misc_ops();
        clear_inputs();
        drive_op(4'b0000, 16'h7FFF, 16'h0000, 1'b1, 16'h0001, 4'd1);
        tick();
        drive_op(4'b1000, 16'h1001, 16'h0000, 1'b1, 16'h0004, 4'd2); mem_read = 1;
        tick();
        n_cmp++; if (out_alu !== 16'h1004 || out_mem_read !== 1'b1 || flags !== 3'b010) begin n_bad++; $display("FAIL lw got %h mr=%b f=%b want 1004/1/010", out_alu, out_mem_read, flags); end
        drive_op(4'b1001, 16'h2003, 16'h5555, 1'b1, 16'h0002, 4'd0); reg_write = 0; mem_write = 1;
        tick();
        n_cmp++; if (out_alu !== 16'h2004 || out_mem_write !== 1'b1 || out_reg_write !== 1'b0 || out_store_data !== 16'h5555) begin n_bad++; $display("FAIL sw got %h mw=%b rw=%b sd=%h want 2004/1/0/5555", out_alu, out_mem_write, out_reg_write, out_store_data); end
        drive_op(4'b1010, 16'hABCD, 16'h0000, 1'b1, 16'h0012, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'hAB12 || flags !== 3'b010) begin n_bad++; $display("FAIL llb got %h/%b want ab12/010", out_alu, flags); end
        drive_op(4'b1011, 16'hABCD, 16'h0000, 1'b1, 16'h0012, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'h12CD) begin n_bad++; $display("FAIL lhb got %h want 12cd", out_alu); end
        drive_op(4'b0011, 16'h1234, 16'h0000, 1'b1, 16'h0001, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'h0000 || out_valid !== 1'b1 || flags !== 3'b010) begin n_bad++; $display("FAIL unsup got %h v=%b f=%b want 0000/1/010", out_alu, out_valid, flags); end
        drive_op(4'b0010, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'h0000 || flags !== 3'b110) begin n_bad++; $display("FAIL xor_z got %h/%b want 0000/110", out_alu, flags); end
        drive_op(4'b0110, 16'h1234, 16'h0000, 1'b1, 16'h0004, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'h4123 || flags !== 3'b010) begin n_bad++; $display("FAIL ror got %h/%b want 4123/010", out_alu, flags); end
        drive_op(4'b0101, 16'h8000, 16'h0000, 1'b1, 16'h0004, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'hF800) begin n_bad++; $display("FAIL sra got %h want f800", out_alu); end
        drive_op(4'b0100, 16'h0003, 16'h0000, 1'b1, 16'h0011, 4'd3);
        tick();
        n_cmp++; if (out_alu !== 16'h0006) begin n_bad++; $display("FAIL sll_mask got %h want 0006", out_alu); end
        drive_op(4'b0100, 16'h0001, 16'h0000, 1'b1, 16'h000F, 4'd3);
        in_valid = 1;
        tick();
        n_cmp++; if (out_alu !== 16'h8000 || flags !== 3'b010) begin n_bad++; $display("FAIL sll15 got %h/%b want 8000/010", out_alu, flags); end
        clear_inputs();
        tick();
        n_cmp++; if (out_valid !== 1'b0 || flags !== 3'b010) begin n_bad++; $display("FAIL bubble got v=%b f=%b want 0/010", out_valid, flags); end
    endtask

    task automatic test_mul();
        int stall_bad = 0;
        int valid_bad = 0;
        clear_inputs();
        drive_op(4'b1111, 16'h0123, 16'h0011, 1'b0, 16'h0000, 4'd9);
        for (int c = 0; c <= 16; c++) begin
            if (c == 1) begin xm_reg_write = 1; xm_rd = 4'd1; xm_alu = 16'hFFFF; end
            #1;
            if (stall !== 1'b1) stall_bad++;
            tick();
            if (out_valid !== 1'b0) valid_bad++;
        end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL mul_stall_window got %0d low cycles want 0", stall_bad); end
        n_cmp++; if (valid_bad != 0) begin n_bad++; $display("FAIL mul_bubbles got %0d valid cycles want 0", valid_bad); end
        clear_inputs();
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mul_done_stall got %b want 0", stall); end
        tick();
        n_cmp++; if (out_alu !== 16'h1353 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mul_result got %h v=%b want 1353/1", out_alu, out_valid); end
        n_cmp++; if (out_rd !== 4'd9 || out_reg_write !== 1'b1 || flags !== 3'b010) begin n_bad++; $display("FAIL mul_ctrl got rd=%h rw=%b f=%b want 9/1/010", out_rd, out_reg_write, flags); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_after got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        drive_op(4'b1111, 16'h0003, 16'h0005, 1'b0, 16'h0000, 4'd4);
        for (int c = 0; c <= 16; c++) tick();
        drive_op(4'b1111, 16'h0007, 16'h0006, 1'b0, 16'h0000, 4'd5);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got %b want 0", stall); end
        tick();
        n_cmp++; if (out_alu !== 16'h000F || out_valid !== 1'b1 || out_rd !== 4'd4) begin n_bad++; $display("FAIL b2b_first got %h v=%b rd=%h want 000f/1/4", out_alu, out_valid, out_rd); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_run got %b want 1", stall); end
        for (int c = 18; c < 33; c++) tick();
        n_cmp++; if (stall !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_last_run got s=%b v=%b want 1/0", stall, out_valid); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_done got %b want 0", stall); end
        tick();
        n_cmp++; if (out_alu !== 16'h002A || out_valid !== 1'b1 || out_rd !== 4'd5) begin n_bad++; $display("FAIL b2b_second got %h v=%b rd=%h want 002a/1/5", out_alu, out_valid, out_rd); end
    endtask

    task automatic test_flush();
        int seen = 0;
        clear_inputs();
        drive_op(4'b0001, 16'h8000, 16'h0000, 1'b1, 16'h0001, 4'd1);
        tick();
        drive_op(4'b0000, 16'h0001, 16'h0000, 1'b1, 16'h0001, 4'd1);
        flush = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || flags !== 3'b011) begin n_bad++; $display("FAIL flush_alu got v=%b rw=%b f=%b want 0/0/011", out_valid, out_reg_write, flags); end
        flush = 0;
        drive_op(4'b1111, 16'h0002, 16'h0003, 1'b0, 16'h0000, 4'd6);
        for (int c = 0; c < 5; c++) tick();
        flush = 1;
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall); end
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
        n_cmp++; if (flags !== 3'b011) begin n_bad++; $display("FAIL flush_flags got %b want 011", flags); end
    endtask

    task automatic test_reset_mid_run();
        clear_inputs();
        drive_op(4'b1111, 16'h0004, 16'h0004, 1'b0, 16'h0000, 4'd2);
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (out_valid !== 1'b0 || out_alu !== 16'h0000 || out_rd !== 4'h0) begin n_bad++; $display("FAIL rst_run_outs got v=%b alu=%h rd=%h want 0/0000/0", out_valid, out_alu, out_rd); end
        n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL rst_run_flags got %b want 000", flags); end
        clear_inputs();
        drive_op(4'b0000, 16'h0002, 16'h0003, 1'b0, 16'h0000, 4'd4);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_run_stall got %b want 0", stall); end
        tick();
        n_cmp++; if (out_alu !== 16'h0005 || out_valid !== 1'b1 || out_rd !== 4'd4) begin n_bad++; $display("FAIL rst_run_add got %h v=%b rd=%h want 0005/1/4", out_alu, out_valid, out_rd); end
        clear_inputs();
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_run_no_result got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_saturation();
        test_misc_ops();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_unit_mc.md
# execute_unit_mc

Parametrised pipelined execute stage: forwards operands from EX/MEM and MEM/WB, computes ALU/address results, and registers them into the EX/MEM pipeline register. It adds a multi-cycle iterative multiplier with a stall handshake toward the decode stage. It also adds a registered Z/V/N flag file. It sits between the ID/EX register and the memory stage.

## Interface
- WIDTH, 16: datapath width; must be ≥ 16.
- REG_BITS, 4: register-index width. Register 0 is never a forwarding source.
- MUL_EN, 1: 1 enables MUL. When 0, MUL is handled as an unsupported op.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of the op in EX
- in_valid  in  1  ID/EX holds a valid op
- opcode  in  4  operation
- reg1, reg2  in  WIDTH  register-file operands (rs, rt)
- imm  in  WIDTH  sign-extended immediate
- alu_src  in  1  B operand = imm
- rs, rt, rd  in  REG_BITS  source and destination indices
- reg_write, mem_read, mem_write  in  1  control bits, passed through
- xm_reg_write, xm_rd, xm_alu  in  1/REG_BITS/WIDTH  EX/MEM forwarding source
- mw_reg_write, mw_rd, mw_data  in  1/REG_BITS/WIDTH  MEM/WB forwarding source
- stall  out  1  upstream must hold ID/EX contents
- out_valid, out_reg_write, out_mem_read, out_mem_write  out  1  EX/MEM register
- out_alu, out_store_data  out  WIDTH  result/address; forwarded rt
- out_rd  out  REG_BITS  destination
- flags  out  3  {Z,V,N}, registered

## Operation
- Forwarding, applied independently to A (rs) and B (rt):
  - First priority: xm_alu, if xm_reg_write and xm_rd==src and src!=0.
  - Second priority: mw_data, if mw_reg_write and mw_rd==src and src!=0.
  - Otherwise: reg1/reg2.
- B operand = alu_src ? imm : forwarded rt.
- out_store_data is always the forwarded rt.
- Opcodes:
  - 0000 ADD, 0001 SUB: signed, saturating to 0x7FFF…/0x800…. Update Z, V, N; V=1 when saturation occurs.
  - 0010 XOR: updates Z.
  - 0100 SLL, 0101 SRA, 0110 ROR: shift amount B[3:0]; update Z.
  - 1000 LW, 1001 SW: result (A+imm) with bit 0 forced to 0; flags unchanged.
  - 1010 LLB: {A[WIDTH-1:8], imm[7:0]}. 1011 LHB: A with bits[15:8] replaced by imm[7:0]. Flags unchanged.
  - 1111 MUL: low WIDTH bits of the unsigned product A×B; updates Z.
  - Any other opcode, or MUL with MUL_EN=0: result 0, flags unchanged, no stall.
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN: on in_valid && opcode==MUL && !flush. At this edge, latch forwarded A/B, clear the accumulator, and load counter=WIDTH.
  - RUN: one shift-add step per cycle, counter decrements. Move to DONE when the step bringing counter to 0 completes.
  - DONE→IDLE: the product is written to the output register at this edge.
- stall=1 combinationally in the IDLE cycle that presents MUL, and throughout RUN. stall=0 in DONE.
- While stall=1, the output register loads a bubble: out_valid=0, all out_* control bits 0.
- Flags update only on the edge where a valid op is registered into out_*. Flags never change on a bubble or a flush.
- flush=1: output register takes a bubble and the FSM returns to IDLE. Any in-flight MUL is discarded, and stall=0 from the next cycle. flush has priority over every other event.

## Timing
- Reset: every out_* is 0, flags=000, FSM in IDLE. stall is 0 in the cycle after reset.
- Non-MUL op, presented in cycle t, is visible on out_* in cycle t+1. stall=0 throughout.
- MUL op presented in cycle t:
  - stall=1 in cycles t..t+WIDTH.
  - DONE occurs in cycle t+WIDTH+1.
  - Result is visible in cycle t+WIDTH+2.
- Operands are latched at cycle t. Forwarding-source changes during RUN do not affect the product.
- Back-to-back MULs: the second MUL is presented in the DONE cycle and enters RUN at that same edge. stall has exactly one low cycle between the two MULs.
- rst during RUN aborts the MUL; no result is ever written.

## Test plan
- Forwarding priority: rs=3, xm_rd=3 with xm_alu=0x0010, mw_rd=3 with mw_data=0x0020, ADD with B=1 → out_alu=0x0011. Repeat with rs=0 → reg1+1.
- Saturation: ADD 0x7FFF+0x0001 → out_alu=0x7FFF, flags=010. SUB 0x8000−0x0001 → 0x8000, flags=011. ADD 5+(−5) → 0x0000, flags=100.
- Memory/LLB: LW with A=0x1001, imm=0x0004 → out_alu=0x1004. LLB with A=0xABCD, imm=0x0012 → 0xAB12, flags unchanged.
- MUL, WIDTH=16: 0x0123×0x0011 presented at cycle 0. stall high cycles 0–16, out_valid=0 during stall. out_alu=0x1353 and out_valid=1 at cycle 18.
- flush at cycle 5 of a MUL: stall=0 from cycle 6, out_valid never rises for that MUL, and flags unchanged.
- Reset mid-RUN: rst at cycle 3 → all outputs 0 and flags=000 at cycle 4. A new ADD presented at cycle 4 appears at cycle 5.
